// File: rtl/sec_timer_bcd.sv
// sec_timer_bcd: mm:ss BCD up/down timer advanced by a synchronized one-per-second tick level input
module sec_timer_bcd #(
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic       dir,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       sec_pulse,
    output logic       done,
    output logic       load_err
);
    localparam logic [7:0] MAX_BCD = 8'(((MAX_MIN / 10) << 4) | (MAX_MIN % 10));

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state, state_nx;
    logic       s1, s2, prev, tick;
    logic [7:0] cnt_min, cnt_sec, min_nx, sec_nx;
    logic       preset_ok, pulse_nx, done_nx, err_nx;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        return v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic is_term(input logic [7:0] m, input logic [7:0] s, input logic d);
        return d ? (m == 8'h00 && s == 8'h00) : (m == MAX_BCD && s == 8'h59);
    endfunction

    assign tick = s2 & ~prev;

    assign cnt_sec = dir ? (sec_bcd == 8'h00 ? 8'h59 : bcd_dec(sec_bcd))
                         : (sec_bcd == 8'h59 ? 8'h00 : bcd_inc(sec_bcd));
    assign cnt_min = dir ? (sec_bcd == 8'h00 ? bcd_dec(min_bcd) : min_bcd)
                         : (sec_bcd == 8'h59 ? bcd_inc(min_bcd) : min_bcd);

    assign preset_ok = preset_min[7:4] <= 4'd9 && preset_min[3:0] <= 4'd9 &&
                       preset_sec[7:4] <= 4'd5 && preset_sec[3:0] <= 4'd9 &&
                       8'(preset_min[7:4]) * 8'd10 + 8'(preset_min[3:0]) <= 8'(MAX_MIN);

    always_comb begin
        state_nx = state;
        min_nx   = min_bcd;
        sec_nx   = sec_bcd;
        pulse_nx = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        if (clear) begin
            state_nx = IDLE;
            min_nx   = 8'h00;
            sec_nx   = 8'h00;
        end else if (load) begin
            if (preset_ok) begin
                state_nx = IDLE;
                min_nx   = preset_min;
                sec_nx   = preset_sec;
            end else begin
                err_nx = 1'b1;
            end
        end else if (stop) begin
            state_nx = state == RUN ? PAUSE : state;
        end else if (start && (state == IDLE || state == PAUSE)) begin
            state_nx = is_term(min_bcd, sec_bcd, dir) ? state : RUN;
        end else if (tick && state == RUN) begin
            // A direction flip can leave RUN sitting on the new terminal; stop there rather than wrap.
            if (is_term(min_bcd, sec_bcd, dir)) begin
                state_nx = DONE;
                done_nx  = 1'b1;
            end else begin
                min_nx   = cnt_min;
                sec_nx   = cnt_sec;
                pulse_nx = 1'b1;
                done_nx  = is_term(cnt_min, cnt_sec, dir);
                state_nx = done_nx ? DONE : RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            prev      <= 1'b0;
            state     <= IDLE;
            min_bcd   <= 8'h00;
            sec_bcd   <= 8'h00;
            running   <= 1'b0;
            sec_pulse <= 1'b0;
            done      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            s1        <= tick_in;
            s2        <= s1;
            prev      <= s2;
            state     <= state_nx;
            min_bcd   <= min_nx;
            sec_bcd   <= sec_nx;
            running   <= state_nx == RUN;
            sec_pulse <= pulse_nx;
            done      <= done_nx;
            load_err  <= err_nx;
        end
    end
endmodule
